// File: rtl/arbitro_escritura.sv
// arbitro_escritura: two-requester write-port arbiter/sequencer for the regfile.
// Define WB_BYPASS_EN to add combinational forwarding from buffers and output.
module arbitro_escritura #(
  parameter int ANCHO_DATO = 32,
  parameter int ANCHO_DIR  = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    vld0,
  output logic                    rdy0,
  input  logic [ANCHO_DIR-1:0]    dir0,
  input  logic [ANCHO_DATO-1:0]   dato0,
  input  logic                    vld1,
  output logic                    rdy1,
  input  logic [ANCHO_DIR-1:0]    dir1,
  input  logic [ANCHO_DATO-1:0]   dato1,
  output logic [ANCHO_DIR-1:0]    diresc,
  output logic [ANCHO_DATO-1:0]   datoesc,
  output logic                    enesc,
  output logic [2**ANCHO_DIR-1:0] pendiente
`ifdef WB_BYPASS_EN
  ,
  input  logic [ANCHO_DIR-1:0]    dirlec1,
  input  logic [ANCHO_DIR-1:0]    dirlec2,
  output logic                    fwd1_vld,
  output logic                    fwd2_vld,
  output logic [ANCHO_DATO-1:0]   fwd1_dato,
  output logic [ANCHO_DATO-1:0]   fwd2_dato
`endif
);

  logic                  lleno0, lleno1;
  logic [ANCHO_DIR-1:0]  b0dir, b1dir;
  logic [ANCHO_DATO-1:0] b0dato, b1dato;
  logic                  difer, viejo, ptr;
  logic                  conc0, conc1;
  logic                  carga0, carga1;
  logic                  queda0, queda1;
  logic                  empate;

  // difer=0 means same age; ptr=1 means a tie goes to requester 1
  assign conc0 = lleno0 & (!lleno1 | (difer ? !viejo : !ptr));
  assign conc1 = lleno1 & (!lleno0 | (difer ? viejo : ptr));

  assign rdy0 = !lleno0 | conc0;
  assign rdy1 = !lleno1 | conc1;

  assign carga0 = vld0 & rdy0 & (dir0 != '0);
  assign carga1 = vld1 & rdy1 & (dir1 != '0);
  assign queda0 = lleno0 & !conc0;
  assign queda1 = lleno1 & !conc1;
  assign empate = lleno0 & lleno1 & !difer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lleno0  <= 1'b0;
      lleno1  <= 1'b0;
      b0dir   <= '0;
      b1dir   <= '0;
      b0dato  <= '0;
      b1dato  <= '0;
      difer   <= 1'b0;
      viejo   <= 1'b0;
      ptr     <= 1'b0;
      enesc   <= 1'b0;
      diresc  <= '0;
      datoesc <= '0;
    end else begin
      lleno0 <= queda0 | carga0;
      lleno1 <= queda1 | carga1;
      if (carga0) begin
        b0dir  <= dir0;
        b0dato <= dato0;
      end
      if (carga1) begin
        b1dir  <= dir1;
        b1dato <= dato1;
      end
      if (carga0 & carga1) begin
        difer <= 1'b0;
      end else if (carga0 & queda1) begin
        difer <= 1'b1;
        viejo <= 1'b1;
      end else if (carga1 & queda0) begin
        difer <= 1'b1;
        viejo <= 1'b0;
      end
      if (empate) ptr <= conc0;
      enesc <= conc0 | conc1;
      if (conc0) begin
        diresc  <= b0dir;
        datoesc <= b0dato;
      end else if (conc1) begin
        diresc  <= b1dir;
        datoesc <= b1dato;
      end
    end
  end

  always_comb begin
    pendiente = '0;
    if (lleno0) pendiente[b0dir] = 1'b1;
    if (lleno1) pendiente[b1dir] = 1'b1;
    if (enesc) pendiente[diresc] = 1'b1;
  end

`ifdef WB_BYPASS_EN
  logic                  joven;
  logic [ANCHO_DIR-1:0]  lec [2];
  logic                  fv [2];
  logic [ANCHO_DATO-1:0] fd [2];
  logic                  my, mo, ms;
  logic [ANCHO_DATO-1:0] dy, dv;

  // joven=1: buffer 1 holds the entry that reaches the port last
  assign joven  = difer ? !viejo : !ptr;
  assign lec[0] = dirlec1;
  assign lec[1] = dirlec2;

  always_comb begin
    my = 1'b0;
    mo = 1'b0;
    ms = 1'b0;
    dy = '0;
    dv = '0;
    for (int k = 0; k < 2; k++) begin
      fv[k] = 1'b0;
      fd[k] = '0;
      my = joven ? (lleno1 && lec[k] == b1dir) : (lleno0 && lec[k] == b0dir);
      mo = joven ? (lleno0 && lec[k] == b0dir) : (lleno1 && lec[k] == b1dir);
      ms = enesc && lec[k] == diresc;
      dy = joven ? b1dato : b0dato;
      dv = joven ? b0dato : b1dato;
      if (lec[k] != '0) begin
        if (my) begin
          fv[k] = 1'b1;
          fd[k] = dy;
        end else if (mo) begin
          fv[k] = 1'b1;
          fd[k] = dv;
        end else if (ms) begin
          fv[k] = 1'b1;
          fd[k] = datoesc;
        end
      end
    end
  end

  assign fwd1_vld  = fv[0];
  assign fwd2_vld  = fv[1];
  assign fwd1_dato = fd[0];
  assign fwd2_dato = fd[1];
`endif

endmodule

// File: doc/arbitro_escritura.md
Name: arbitro_escritura

Overview:
- Write-port arbiter and sequencer for the 32x32 register file. The register file has a single write port (diresc/datoesc/enesc).
- Two producers compete for that port: requester 0 (ALU writeback) and requester 1 (memory-load writeback). Each has a single-entry holding buffer.
- Grants go to buffered writes in age order, round-robin on ties, and drive the write port from registered outputs.
- A per-register pending vector is exported for hazard detection in the decode stage.

Parameters:
- ANCHO_DATO, 32, data width of a write.
- ANCHO_DIR, 5, register address width (2**ANCHO_DIR registers).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- vld0  in  1  requester 0 write valid.
- rdy0  out  1  requester 0 ready.
- dir0  in  ANCHO_DIR  requester 0 destination register.
- dato0  in  ANCHO_DATO  requester 0 write data.
- vld1 / rdy1 / dir1 / dato1: same as requester 0, for requester 1.
- diresc  out  ANCHO_DIR  register-file write address (registered).
- datoesc  out  ANCHO_DATO  register-file write data (registered).
- enesc  out  1  register-file write enable (registered).
- pendiente  out  2**ANCHO_DIR  bit k=1 while a write to register k is buffered or on the output stage.

Behaviour:
- Reset (async, rst_n=0):
  - Both buffers empty, age flag cleared, round-robin pointer favours requester 0.
  - enesc=0, diresc=0, datoesc=0, pendiente=0.
  - Writes in flight are discarded. No write may reach the port after reset asserts.
- Handshake:
  - rdyi = !llenoi | conci (combinational), where conci is the grant to buffer i this cycle.
  - A transfer occurs on a rising edge with vldi&rdyi=1. dir/dato are captured into buffer i.
  - vldi must hold stable until the transfer. rdy never depends on vld.
- Register zero: a transfer with diri=0 is accepted (rdy honoured) but dropped. The buffer stays empty, no enesc, and no pendiente bit is set.
- Age tracking: viejo records which buffer holds the older entry.
  - It is set when a buffer loads while the other is full and not being granted.
  - Entries loaded on the same edge are same-age.
- Arbitration, evaluated every cycle:
  - Neither buffer full: no grant.
  - One buffer full: grant it.
  - Both full, different ages: grant the older.
  - Both full, same age: grant the buffer not granted last. The pointer updates only on a grant from this tie case.
- Output stage:
  - On a grant, the next edge loads diresc/datoesc from the granted buffer, sets enesc=1 and empties that buffer.
  - With no grant, the next edge sets enesc=0. diresc/datoesc hold their last values.
  - One write per cycle maximum. Back-to-back grants give continuous enesc=1.
- Latency:
  - Handshake edge N, buffer full after N, uncontended: enesc=1 during cycle N+1..N+2.
  - Throughput: one write per cycle sustained.
- pendiente: OR of decoded full buffers and (enesc ? diresc : none). Bit 0 is always 0. A bit clears the cycle after its write leaves the output stage.
- Simultaneous load and grant of the same buffer: the grant empties the old entry and the load fills it on the same edge. The buffer stays full with the new entry.

Optional Feature:
- Macro: WB_BYPASS_EN.
- When defined, add these ports:
  - dirlec1, dirlec2  in  ANCHO_DIR.
  - fwd1_vld, fwd2_vld  out  1.
  - fwd1_dato, fwd2_dato  out  ANCHO_DATO.
- Combinational forwarding:
  - fwdN_vld=1 when dirlecN≠0 matches a full buffer or the output stage with enesc=1.
  - fwdN_dato takes the youngest match. Priority: younger buffer, then older buffer, then output stage.
- When undefined: no extra ports or logic.

Test Plan:
- Reset: rst_n=0 mid-stream with both buffers full -> enesc=0, pendiente=0 immediately. After release, rdy0=rdy1=1 and no stale write appears.
- Single write: vld0=1, dir0=7, dato0=0xDEADBEEF, accepted at edge N -> at edge N+1 enesc=1, diresc=7, datoesc=0xDEADBEEF. pendiente[7]=1 from N to N+2, 0 afterwards.
- Same-age contention:
  - Stimulus: vld0/vld1 asserted on the same edge, dir0=3/dato0=0x11, dir1=4/dato1=0x22.
  - Required: port writes reg3 then reg4 on consecutive cycles.
  - Repeat the stimulus: order becomes reg4 then reg3.
- Age ordering to the same register:
  - Stimulus: load buffer1 with dir=5/0xAA, hold it blocked by a reg-9 write still in buffer0 under contention, then load buffer0 with dir=5/0xBB.
  - Required: 0xAA is written before 0xBB, and the final register 5 value is 0xBB.
- Register zero and backpressure:
  - dir0=0 -> rdy0=1, no enesc, pendiente unchanged.
  - 4 back-to-back writes on requester 0 -> enesc high 4 consecutive cycles, rdy0 never low.
- WB_BYPASS_EN: buffer0 holds reg12=0x55 while the output stage writes reg12=0x44, dirlec1=12 -> fwd1_vld=1, fwd1_dato=0x55.
